// File: rtl/cmd_seq_pkg.sv
// Shared definitions for the multi-lane command sequencer: FSM encoding,
// width helpers and the default idle line level.
package cmd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    localparam logic IDLE_LVL_DEF = 1'b0;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int bit_cnt_width(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

endpackage

// File: rtl/cmd_seq_ram.sv
// Pattern RAM: one write port and one registered read port; a read and a
// write to the same address in one cycle return the old word.
module cmd_seq_ram #(
    parameter int DEPTH  = 256,
    parameter int WORD_W = 16,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [WORD_W-1:0] rdata_r;

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // registered read port, sampled every cycle
    always_ff @(posedge clk) begin
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/cmd_seq_mc.sv
// Multi-lane command serializer: replays a RAM-held pattern MSB-first on NCH
// lanes with per-lane enable/invert, repetition count or endless looping.
module cmd_seq_mc
    import cmd_seq_pkg::*;
#(
    parameter int   NCH      = 4,
    parameter int   WORD_W   = 16,
    parameter int   DEPTH    = 256,
    parameter int   REP_W    = 16,
    parameter logic IDLE_LVL = IDLE_LVL_DEF,
    localparam int  AW       = addr_width(DEPTH)
) (
    input  logic              CMD_CLK,
    input  logic              CMD_RST_N,
    input  logic              MEM_WE,
    input  logic [AW-1:0]     MEM_WADDR,
    input  logic [WORD_W-1:0] MEM_WDATA,
    input  logic              START,
    input  logic              STOP,
    input  logic [AW:0]       SIZE,
    input  logic [REP_W-1:0]  REPETITIONS,
    input  logic [NCH-1:0]    CH_EN,
    input  logic [NCH-1:0]    CH_INV,
    input  logic              EXT_START_EN,
    input  logic              EXT_START_PIN,
    output logic [NCH-1:0]    CMD_SERIAL_OUT,
    output logic [NCH-1:0]    CMD_OUTPUT_EN,
    output logic              CMD_WRITING,
    output logic              CMD_LOOP_START,
    output logic              DONE
);

    localparam int BW = bit_cnt_width(WORD_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
    localparam logic [BW-1:0] BIT_PREF = BW'(WORD_W - 2);

    state_e            state_r, state_nxt_s;
    logic [2:0]        ext_sync_r;
    logic [AW:0]       size_l_r;
    logic [REP_W-1:0]  reps_l_r, rep_cnt_r, rep_inc_s;
    logic [NCH-1:0]    ch_en_l_r, ser_r, oe_r;
    logic [AW-1:0]     addr_r, next_addr_s;
    logic [BW-1:0]     bit_cnt_r;
    logic [WORD_W-1:0] shift_r, rdata_s, word_s;
    logic              stop_pend_r, writing_r, loop_start_r, end_r, done_r;
    logic              start_s, launch_s, bit_s, last_bit_s, loop_end_s, finish_s;

    cmd_seq_ram #(.DEPTH(DEPTH), .WORD_W(WORD_W), .AW(AW)) u_ram (
        .clk   (CMD_CLK),
        .we    (MEM_WE),
        .waddr (MEM_WADDR),
        .wdata (MEM_WDATA),
        .raddr (addr_r),
        .rdata (rdata_s)
    );

    assign start_s  = START | (EXT_START_EN & ext_sync_r[1] & ~ext_sync_r[2]);
    assign launch_s = (state_r == ST_IDLE) && start_s && (SIZE != '0);

    // The first bit of each word comes straight from the RAM output register.
    assign word_s      = (bit_cnt_r == '0) ? rdata_s : shift_r;
    assign bit_s       = word_s[WORD_W-1];
    assign last_bit_s  = (state_r == ST_SHIFT) && (bit_cnt_r == BIT_LAST);
    // addr_r already holds the prefetched address on the last bit, so 0 means wrap
    assign loop_end_s  = last_bit_s && (addr_r == '0);
    assign rep_inc_s   = rep_cnt_r + REP_W'(1);
    assign finish_s    = last_bit_s && (stop_pend_r || STOP ||
                         (loop_end_s && (reps_l_r != '0) && (rep_inc_s == reps_l_r)));
    assign next_addr_s = ({1'b0, addr_r} == (size_l_r - (AW+1)'(1))) ? '0 : addr_r + AW'(1);

    // external start pin synchronizer and edge history
    always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
        if (!CMD_RST_N) begin
            ext_sync_r <= '0;
        end else begin
            ext_sync_r <= {ext_sync_r[1:0], EXT_START_PIN};
        end
    end

    // FSM state register
    always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
        if (!CMD_RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (launch_s) state_nxt_s = ST_FETCH; else state_nxt_s = ST_IDLE;
            ST_FETCH: state_nxt_s = ST_SHIFT;
            ST_SHIFT: if (finish_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_SHIFT;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // sequence configuration latch, counters and shift register
    always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
        if (!CMD_RST_N) begin
            size_l_r    <= '0;
            reps_l_r    <= '0;
            ch_en_l_r   <= '0;
            addr_r      <= '0;
            bit_cnt_r   <= '0;
            rep_cnt_r   <= '0;
            stop_pend_r <= 1'b0;
            shift_r     <= '0;
        end else if (launch_s) begin
            size_l_r    <= SIZE;
            reps_l_r    <= REPETITIONS;
            ch_en_l_r   <= CH_EN;
            addr_r      <= '0;
            bit_cnt_r   <= '0;
            rep_cnt_r   <= '0;
            stop_pend_r <= 1'b0;
        end else if (state_r == ST_SHIFT) begin
            shift_r   <= word_s << 1;
            bit_cnt_r <= last_bit_s ? '0 : bit_cnt_r + BW'(1);
            if (bit_cnt_r == BIT_PREF) begin
                addr_r <= next_addr_s;
            end
            if (loop_end_s) begin
                rep_cnt_r <= rep_inc_s;
            end
            if (STOP) begin
                stop_pend_r <= 1'b1;
            end
        end else if ((state_r == ST_FETCH) && STOP) begin
            stop_pend_r <= 1'b1;
        end
    end

    // registered lane and status outputs
    always_ff @(posedge CMD_CLK or negedge CMD_RST_N) begin
        if (!CMD_RST_N) begin
            ser_r        <= {NCH{IDLE_LVL}};
            oe_r         <= '0;
            writing_r    <= 1'b0;
            loop_start_r <= 1'b0;
            end_r        <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            ser_r        <= (state_r == ST_SHIFT) ?
                            ((ch_en_l_r & {NCH{bit_s}}) | (~ch_en_l_r & {NCH{IDLE_LVL}})) :
                            {NCH{IDLE_LVL}};
            oe_r         <= (state_r == ST_SHIFT) ? ch_en_l_r : '0;
            writing_r    <= (state_nxt_s != ST_IDLE) || finish_s;
            loop_start_r <= (state_r == ST_SHIFT) && (bit_cnt_r == '0) && (addr_r == '0);
            end_r        <= finish_s;
            done_r       <= end_r;
        end
    end

    // polarity is applied live so it also affects the idle level
    assign CMD_SERIAL_OUT = ser_r ^ CH_INV;
    assign CMD_OUTPUT_EN  = oe_r;
    assign CMD_WRITING    = writing_r;
    assign CMD_LOOP_START = loop_start_r;
    assign DONE           = done_r;

endmodule

// File: tb/tb_cmd_seq_mc.sv
// Self-checking bench for cmd_seq_mc: table-driven pattern runs scored
// against a per-cycle expected trace, plus directed corner sequences.
module tb_cmd_seq_mc;

    typedef struct packed {
        logic [3:0] ser;
        logic [3:0] oe;
        logic       wr;
        logic       ls;
        logic       dn;
    } out_t;

    typedef struct {
        logic [8:0]       size;
        logic [15:0]      reps;
        logic [3:0]       en;
        logic [3:0]       inv;
        logic [3:0][15:0] w;
        int               exp_bits;
        int               exp_loops;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic        start, stop;
    logic [8:0]  size;
    logic [15:0] reps;
    logic [3:0]  ch_en, ch_inv;
    logic        ext_en, ext_pin;
    logic [3:0]  ser, oe;
    logic        writing, loop_start, done;

    out_t  sb_q[$];
    out_t  got_o, exp_o;
    int    n_checks = 0;
    int    n_fail = 0;
    int    oe_cycles, ls_cnt, done_cnt, wr_cycles;
    string cur_name = "reset";

    always #5 clk = ~clk;

    cmd_seq_mc dut (
        .CMD_CLK        (clk),
        .CMD_RST_N      (rst_n),
        .MEM_WE         (mem_we),
        .MEM_WADDR      (mem_waddr),
        .MEM_WDATA      (mem_wdata),
        .START          (start),
        .STOP           (stop),
        .SIZE           (size),
        .REPETITIONS    (reps),
        .CH_EN          (ch_en),
        .CH_INV         (ch_inv),
        .EXT_START_EN   (ext_en),
        .EXT_START_PIN  (ext_pin),
        .CMD_SERIAL_OUT (ser),
        .CMD_OUTPUT_EN  (oe),
        .CMD_WRITING    (writing),
        .CMD_LOOP_START (loop_start),
        .DONE           (done)
    );

    // Scoreboard monitor: one expected record per cycle while the queue holds any.
    always @(posedge clk) begin
        #1;
        if (|oe) oe_cycles++;
        if (loop_start) ls_cnt++;
        if (done) done_cnt++;
        if (writing) wr_cycles++;
        if (sb_q.size() > 0) begin
            exp_o = sb_q.pop_front();
            got_o = '{ser: ser, oe: oe, wr: writing, ls: loop_start, dn: done};
            n_checks++;
            if (got_o !== exp_o) begin
                n_fail++;
                $display("FAIL %s trace: got ser=%b oe=%b wr=%b ls=%b dn=%b, required ser=%b oe=%b wr=%b ls=%b dn=%b",
                         cur_name, got_o.ser, got_o.oe, got_o.wr, got_o.ls, got_o.dn,
                         exp_o.ser, exp_o.oe, exp_o.wr, exp_o.ls, exp_o.dn);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic clear_counts();
        oe_cycles = 0; ls_cnt = 0; done_cnt = 0; wr_cycles = 0;
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    // Expected trace: FETCH + first SHIFT cycle, n_words words of bits, DONE, one idle.
    task automatic push_trace(input logic [3:0][15:0] w, input int sz, input int n_words,
                              input logic [3:0] en, input logic [3:0] inv);
        out_t r;
        r = '{ser: inv, oe: 4'b0000, wr: 1'b1, ls: 1'b0, dn: 1'b0};
        sb_q.push_back(r);
        sb_q.push_back(r);
        for (int j = 0; j < n_words; j++) begin
            for (int b = 15; b >= 0; b--) begin
                logic bt;
                bt    = w[j % sz][b];
                r.ser = ({4{bt}} & en) ^ inv;
                r.oe  = en;
                r.wr  = 1'b1;
                r.ls  = ((j % sz) == 0) && (b == 15);
                r.dn  = 1'b0;
                sb_q.push_back(r);
            end
        end
        r = '{ser: inv, oe: 4'b0000, wr: 1'b0, ls: 1'b0, dn: 1'b1};
        sb_q.push_back(r);
        r.dn = 1'b0;
        sb_q.push_back(r);
    endtask

    task automatic wait_drain(input int budget);
        int cnt;
        cnt = 0;
        while (sb_q.size() > 0 && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d records left, required 0", cur_name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    vec_t vecs[4];
    logic [3:0][15:0] ws;
    int wr_first, oe_first;

    initial begin
        vecs[0] = '{size: 9'd2, reps: 16'd1, en: 4'b0101, inv: 4'b0000,
                    w: {16'h0000, 16'h0000, 16'h0F0F, 16'hA5F0}, exp_bits: 32, exp_loops: 1};
        vecs[1] = '{size: 9'd1, reps: 16'd3, en: 4'b1111, inv: 4'b0000,
                    w: {16'h0000, 16'h0000, 16'h0000, 16'h8001}, exp_bits: 48, exp_loops: 3};
        vecs[2] = '{size: 9'd2, reps: 16'd2, en: 4'b1111, inv: 4'b1111,
                    w: {16'h0000, 16'h0000, 16'h1234, 16'hC3A5}, exp_bits: 64, exp_loops: 2};
        vecs[3] = '{size: 9'd3, reps: 16'd1, en: 4'b1010, inv: 4'b0110,
                    w: {16'h0000, 16'h8000, 16'h0001, 16'hFFFF}, exp_bits: 48, exp_loops: 1};

        rst_n = 1'b0; mem_we = 1'b0; mem_waddr = 8'd0; mem_wdata = 16'd0;
        start = 1'b0; stop = 1'b0; size = 9'd0; reps = 16'd0;
        ch_en = 4'b0000; ch_inv = 4'b0000; ext_en = 1'b0; ext_pin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ser", {28'd0, ser}, 32'h0);
        check("reset_ctl", {27'd0, oe, writing, loop_start, done}, 32'h0);
        rst_n = 1'b1;

        // table-driven pattern runs
        for (int v = 0; v < 4; v++) begin
            cur_name = $sformatf("vec%0d", v);
            for (int k = 0; k < 4; k++) mem_write(8'(k), vecs[v].w[k]);
            @(negedge clk);
            ch_inv = vecs[v].inv; ch_en = vecs[v].en;
            size = vecs[v].size; reps = vecs[v].reps;
            #1;
            check({cur_name, "_idle_lvl"}, {28'd0, ser}, {28'd0, vecs[v].inv});
            @(negedge clk);
            clear_counts();
            push_trace(vecs[v].w, int'(vecs[v].size), int'(vecs[v].size) * int'(vecs[v].reps),
                       vecs[v].en, vecs[v].inv);
            pulse_start();
            ch_en = ~vecs[v].en; size = 9'd0; reps = 16'd7;
            wait_drain(400);
            check({cur_name, "_bits"}, oe_cycles, vecs[v].exp_bits);
            check({cur_name, "_loops"}, ls_cnt, vecs[v].exp_loops);
            check({cur_name, "_done"}, done_cnt, 1);
        end

        // endless mode, STOP mid word 2 of loop 5
        cur_name = "endless_stop";
        ws = {16'hBDF1, 16'hACE0, 16'h2468, 16'h1357};
        for (int k = 0; k < 4; k++) mem_write(8'(k), ws[k]);
        @(negedge clk);
        ch_inv = 4'b0000; ch_en = 4'b1111; size = 9'd4; reps = 16'd0;
        clear_counts();
        push_trace(ws, 4, 19, 4'b1111, 4'b0000);
        pulse_start();
        repeat (294) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_drain(500);
        check("endless_done", done_cnt, 1);
        check("endless_loops", ls_cnt, 5);

        // STOP in idle and START with SIZE=0 are inert
        cur_name = "idle_inert";
        for (int k = 0; k < 3; k++) sb_q.push_back('{ser: 4'b0000, oe: 4'b0000, wr: 1'b0, ls: 1'b0, dn: 1'b0});
        stop = 1'b1; size = 9'd0;
        @(negedge clk);
        stop = 1'b0;
        pulse_start();
        wait_drain(10);

        // second START while busy is ignored
        cur_name = "busy_start";
        ws = {16'h0000, 16'h0000, 16'h0000, 16'hF00F};
        mem_write(8'd0, 16'hF00F);
        @(negedge clk);
        size = 9'd1; reps = 16'd2; ch_en = 4'b0011;
        clear_counts();
        push_trace(ws, 1, 2, 4'b0011, 4'b0000);
        pulse_start();
        repeat (6) @(negedge clk);
        pulse_start();
        wait_drain(100);
        check("busy_done", done_cnt, 1);

        // external start: disabled, then enabled
        cur_name = "ext_start";
        size = 9'd1; reps = 16'd1; ch_en = 4'b1111;
        @(negedge clk);
        clear_counts();
        #1 ext_pin = 1'b1;
        repeat (3) @(negedge clk);
        ext_pin = 1'b0;
        repeat (6) @(negedge clk);
        check("ext_disabled", wr_cycles, 0);
        ext_en = 1'b1;
        wr_first = 0; oe_first = 0;
        #1 ext_pin = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (wr_first == 0 && writing) wr_first = i;
            if (oe_first == 0 && (|oe)) oe_first = i;
        end
        ext_pin = 1'b0;
        check("ext_latency", (wr_first >= 3 && wr_first <= 4) ? 32'd1 : 32'd0, 32'd1);
        check("ext_first_bit", oe_first, wr_first + 2);
        repeat (30) @(negedge clk);
        check("ext_done", done_cnt, 1);
        ext_en = 1'b0;

        // reset mid-sequence, then SIZE=0 start stays idle
        cur_name = "mid_reset";
        size = 9'd2; reps = 16'd0; ch_en = 4'b1111; ch_inv = 4'b0011;
        @(negedge clk);
        pulse_start();
        repeat (20) @(negedge clk);
        clear_counts();
        rst_n = 1'b0;
        #1;
        check("mid_reset_ser", {28'd0, ser}, 32'h3);
        check("mid_reset_ctl", {27'd0, oe, writing, loop_start, done}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_reset_no_done", done_cnt, 0);
        size = 9'd0;
        for (int k = 0; k < 4; k++) sb_q.push_back('{ser: 4'b0011, oe: 4'b0000, wr: 1'b0, ls: 1'b0, dn: 1'b0});
        pulse_start();
        wait_drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
